bus_master: RTL and testbench

BUS_MASTER -- requirements
Module: bus_master

---
 rtl/bus_master.sv | 130 +++++++++++++
 tb/tb_bus_master.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master.sv
// rtl/bus_master.sv - single-outstanding command-to-bus master with a programmable read wait.
// One command is in flight at a time; reads hold their response until it is consumed.
module bus_master #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        bus_wr,
  output logic        bus_rd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data_i,
  input  logic [31:0] bus_data_o,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_RESP
  } state_t;

  // WAIT runs READ_LATENCY cycles, so the counter starts one below it.
  localparam logic [3:0] LP_WAIT_INIT = (READ_LATENCY == 0) ? 4'd0 : 4'(READ_LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_bus_wr;
  logic        r_bus_rd;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_data;
  logic [15:0] r_wr_count;
  logic [15:0] r_rd_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 4'd0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_bus_wr    <= 1'b0;
      r_bus_rd    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_data  <= 32'd0;
      r_wr_count  <= 16'd0;
      r_rd_count  <= 16'd0;
    end else begin
      r_bus_wr <= 1'b0;
      r_bus_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_bus_addr  <= cmd_addr;
            if (cmd_we) begin
              r_bus_wr   <= 1'b1;
              r_bus_data <= cmd_wdata;
              r_state    <= S_WRITE;
            end else begin
              r_bus_rd <= 1'b1;
              r_state  <= S_READ;
            end
          end
        end
        S_WRITE: begin
          r_wr_count  <= r_wr_count + 16'd1;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_READ: begin
          r_rd_count <= r_rd_count + 16'd1;
          if (READ_LATENCY == 0) begin
            r_rsp_rdata <= bus_data_o;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wait_cnt <= LP_WAIT_INIT;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_rsp_rdata <= bus_data_o;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign bus_wr     = r_bus_wr;
  assign bus_rd     = r_bus_rd;
  assign bus_addr   = r_bus_addr;
  assign bus_data_i = r_bus_data;
  assign wr_count   = r_wr_count;
  assign rd_count   = r_rd_count;

endmodule

// File: tb/tb_bus_master.sv
// tb/tb_bus_master.sv - randomized bench for bus_master with a timestamp-based reference model.
module tb_bus_master;

  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_addr;
  logic [31:0] bus_data_i;
  logic [31:0] bus_data_o = 32'd0;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  int n_vec = 0;
  int n_err = 0;
  int n_wr_iss = 0;
  int n_rd_iss = 0;
  bit rr_mode = 1'b0;
  bit rr_val = 1'b0;
  bit preset_req = 1'b0;

  always #5 clk = ~clk;

  bus_master #(.READ_LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_addr(bus_addr), .bus_data_i(bus_data_i),
    .bus_data_o(bus_data_o), .wr_count(wr_count), .rd_count(rd_count)
  );

  // Extra instances only measure the latency extremes against a fixed data pattern.
  logic [1:0]  lt_cmd_valid = 2'b00;
  logic [31:0] lt_cmd_addr = 32'd0;
  logic [1:0]  lt_cmd_ready;
  logic [1:0]  lt_rsp_valid;
  logic [1:0]  lt_bus_rd;
  logic [31:0] lt_rsp_rdata [2];
  logic [31:0] lt_bus_addr [2];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_lat
      localparam int unsigned LT_LAT = (g == 0) ? 0 : 15;
      logic [31:0] bdo = 32'd0;
      logic [31:0] w_bus_data_i;
      logic [15:0] w_wrc;
      logic [15:0] w_rdc;
      logic        w_bus_wr;
      bit          pend = 1'b0;
      int          cnt = 0;
      logic [31:0] pdata = 32'd0;
      bus_master #(.READ_LATENCY(LT_LAT)) u_dut_lat (
        .clk(clk), .rst_n(rst_n), .cmd_valid(lt_cmd_valid[g]), .cmd_ready(lt_cmd_ready[g]),
        .cmd_we(1'b0), .cmd_addr(lt_cmd_addr), .cmd_wdata(32'd0),
        .rsp_valid(lt_rsp_valid[g]), .rsp_ready(1'b1), .rsp_rdata(lt_rsp_rdata[g]),
        .bus_wr(w_bus_wr), .bus_rd(lt_bus_rd[g]), .bus_addr(lt_bus_addr[g]),
        .bus_data_i(w_bus_data_i), .bus_data_o(bdo), .wr_count(w_wrc), .rd_count(w_rdc)
      );
      always @(posedge clk) begin
        #1;
        if (lt_bus_rd[g]) begin
          pend = 1'b1;
          cnt = int'(LT_LAT);
          pdata = 32'hC0DE0000 | {28'd0, lt_bus_addr[g][3:0]};
        end else if (pend && cnt > 0) begin
          cnt = cnt - 1;
        end
        if (pend && cnt == 0) begin
          bdo = pdata;
          pend = 1'b0;
        end else begin
          bdo = $urandom;
        end
      end
    end
  endgenerate

  // Slave for the main instance: memory indexed by addr[3:0], data valid LAT cycles after bus_rd.
  logic [31:0] s_mem [16] = '{default: 32'd0};
  bit          s_pend = 1'b0;
  int          s_cnt = 0;
  logic [31:0] s_pdata = 32'd0;

  always @(posedge clk) begin
    #1;
    if (bus_wr) s_mem[bus_addr[3:0]] = bus_data_i;
    if (bus_rd) begin
      s_pend = 1'b1;
      s_cnt = int'(LAT);
      s_pdata = s_mem[bus_addr[3:0]];
    end else if (s_pend && s_cnt > 0) begin
      s_cnt = s_cnt - 1;
    end
    if (s_pend && s_cnt == 0) begin
      bus_data_o = s_pdata;
      s_pend = 1'b0;
    end else begin
      bus_data_o = $urandom;
    end
  end

  always @(negedge clk) rsp_ready = rr_mode ? 1'($urandom_range(0, 1)) : rr_val;

  // Reference model: events are placed by cycle timestamps relative to command acceptance.
  int          n = 0;
  int          t_resp = 0;
  bit          m_seen_rst = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_armed = 1'b0;
  bit          was_busy, pw, pr, pv;
  logic [31:0] m_rd_addr = 32'd0;
  logic [31:0] m_mem [16] = '{default: 32'd0};
  logic        e_wr = 1'b0, e_rd = 1'b0, e_rvalid = 1'b0, e_cready = 1'b1;
  logic [31:0] e_addr = 32'd0, e_wd = 32'd0, e_rdata = 32'd0;
  logic [15:0] e_wrc = 16'd0, e_rdc = 16'd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_seen_rst = 1'b1;
      m_busy = 1'b0;
      m_armed = 1'b0;
      e_wr = 1'b0; e_rd = 1'b0; e_rvalid = 1'b0; e_cready = 1'b1;
      e_addr = 32'd0; e_wd = 32'd0; e_rdata = 32'd0;
      e_wrc = 16'd0; e_rdc = 16'd0;
    end else begin
      was_busy = m_busy;
      pw = e_wr;
      pr = e_rd;
      pv = e_rvalid;
      e_wr = 1'b0;
      e_rd = 1'b0;
      if (pw) begin
        e_wrc = e_wrc + 16'd1;
        m_busy = 1'b0;
      end
      if (pr) begin
        e_rdc = e_rdc + 16'd1;
        t_resp = n + int'(LAT) + 1;
        m_armed = 1'b1;
      end
      if (pv && rsp_ready) begin
        e_rvalid = 1'b0;
        m_busy = 1'b0;
      end
      if (m_armed && n + 1 == t_resp) begin
        e_rvalid = 1'b1;
        e_rdata = m_mem[m_rd_addr[3:0]];
        m_armed = 1'b0;
      end
      if (!was_busy && cmd_valid) begin
        m_busy = 1'b1;
        e_addr = cmd_addr;
        if (cmd_we) begin
          e_wr = 1'b1;
          e_wd = cmd_wdata;
          m_mem[cmd_addr[3:0]] = cmd_wdata;
        end else begin
          e_rd = 1'b1;
          m_rd_addr = cmd_addr;
        end
      end
      if (preset_req) e_wrc = 16'hFFFF;
      e_cready = !m_busy;
    end
    n = n + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_seen_rst) begin
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e_cready});
      chk("bus_wr", {31'd0, bus_wr}, {31'd0, e_wr});
      chk("bus_rd", {31'd0, bus_rd}, {31'd0, e_rd});
      chk("strobe_overlap", {31'd0, bus_wr & bus_rd}, 32'd0);
      chk("bus_addr", bus_addr, e_addr);
      chk("bus_data_i", bus_data_i, e_wd);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_rvalid});
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("wr_count", {16'd0, wr_count}, {16'd0, e_wrc});
      chk("rd_count", {16'd0, rd_count}, {16'd0, e_rdc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic do_cmd(input logic we, input logic [31:0] a, input logic [31:0] d);
    int k;
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_addr = a;
    cmd_wdata = d;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_we = 1'($urandom_range(0, 1));
    cmd_addr = $urandom;
    cmd_wdata = $urandom;
    if (we) n_wr_iss++;
    else n_rd_iss++;
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    for (int i = 0; i < 2; i++) begin
      chk("lt_cmd_ready", {31'd0, lt_cmd_ready[i]}, 32'd1);
      lt_cmd_addr = 32'h2 + i;
      lt_cmd_valid[i] = 1'b1;
      tick();
      lt_cmd_valid[i] = 1'b0;
      k = 1;
      while (!lt_rsp_valid[i] && k < 40) begin
        tick();
        k++;
      end
      chk("lt_latency", 32'(k), (i == 0) ? 32'd2 : 32'd17);
      chk("lt_rdata", lt_rsp_rdata[i], 32'hC0DE0000 | (32'h2 + i));
      repeat (2) tick();
    end

    do_cmd(1'b1, 32'h10, 32'hDEADBEEF);
    chk("wr_strobe", {31'd0, bus_wr}, 32'd1);
    chk("wr_addr", bus_addr, 32'h10);
    chk("wr_data", bus_data_i, 32'hDEADBEEF);
    tick();
    chk("wr_done", {31'd0, bus_wr}, 32'd0);
    chk("wr_ready", {31'd0, cmd_ready}, 32'd1);
    chk("wr_count1", {16'd0, wr_count}, 32'd1);

    do_cmd(1'b1, 32'h4, 32'h12345678);
    tick();
    rr_val = 1'b1;
    do_cmd(1'b0, 32'h4, 32'h0);
    chk("rd_T", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("rd_T1", {31'd0, rsp_valid}, 32'd0);
    chk("rd_count1", {16'd0, rd_count}, 32'd1);
    tick();
    chk("rd_T2", {31'd0, rsp_valid}, 32'd1);
    chk("rd_T2_data", rsp_rdata, 32'h12345678);
    tick();
    chk("rd_T3", {31'd0, rsp_valid}, 32'd0);

    rr_val = 1'b0;
    do_cmd(1'b1, 32'h8, 32'hA5A5A5A5);
    do_cmd(1'b0, 32'h8, 32'h0);
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick();
      k++;
    end
    repeat (5) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_rdata, 32'hA5A5A5A5);
      chk("bp_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_strobes", {30'd0, bus_wr, bus_rd}, 32'd0);
      tick();
    end
    rr_val = 1'b1;
    tick();
    chk("bp_idle", {31'd0, cmd_ready}, 32'd1);

    rr_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 1)) tick();
      do_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
    end
    rr_mode = 1'b0;
    rr_val = 1'b1;
    repeat (30) tick();
    chk("wr_total", {16'd0, wr_count}, {16'd0, 16'(n_wr_iss)});
    chk("rd_total", {16'd0, rd_count}, {16'd0, 16'(n_rd_iss)});

    @(negedge clk);
    #1;
    force u_dut.r_wr_count = 16'hFFFF;
    preset_req = 1'b1;
    @(posedge clk);
    #1;
    release u_dut.r_wr_count;
    preset_req = 1'b0;
    chk("wrap_preset", {16'd0, wr_count}, 32'h0000FFFF);
    do_cmd(1'b1, 32'h5, 32'h0BADF00D);
    tick();
    chk("wrap_zero", {16'd0, wr_count}, 32'd0);

    do_cmd(1'b0, 32'h3, 32'h0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rstw_bus_rd", {31'd0, bus_rd}, 32'd0);
    chk("rstw_addr", bus_addr, 32'd0);
    chk("rstw_data", bus_data_i, 32'd0);
    chk("rstw_rdata", rsp_rdata, 32'd0);
    chk("rstw_counts", {wr_count, rd_count}, 32'd0);
    rst_n = 1'b1;
    repeat (20) begin
      chk("rstw_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule
